ql_bl_wl_config_loader: RTL and testbench
=========================================

// Module: ql_bl_wl_config_loader
// PURPOSE
//  Programs the fabric's configuration memory.
//  - Accepts a stream of configuration words over a valid/ready interface.
//  - Assembles each stream of words into one bit-line (BL) frame.
//  - Pulses a single word-line (WL) row to write that frame, then moves on to the next row.
//  - Drives fpga_top bl_config_region_0/wl_config_region_0 directly; it replaces the text-file bitstream preload.
// PARAMETERS
//  BL_W      514  bit-line width (bits per row frame)
//  WL_W      407  word-line count (rows per bitstream)
//  DIN_W     32   stream word width; CHUNKS = ceil(BL_W/DIN_W) words per row
//  WL_PULSE  2    cycles each WL row is held high (>=1)
// PORTS
//  clk            in   1         config clock; all state on rising edge
//  global_resetn  in   1         asynchronous active-low reset
//  start          in   1         1-cycle request to begin a full load; honoured only in IDLE/DONE
//  abort          in   1         synchronous abort; return to IDLE from any state
//  s_data         in   DIN_W     config word; bit i of chunk k -> bl[k*DIN_W+i]
//  s_valid        in   1         s_data valid
//  s_ready        out  1         loader accepts s_data this cycle
//  bl             out  [0:BL_W-1] bit-line frame to fabric
//  wl             out  [0:WL_W-1] one-hot-or-zero word-line select
//  busy           out  1         load in progress (LOAD..HOLD)
//  done           out  1         full bitstream written; level, cleared by next start/abort
// BEHAVIOUR
//  Reset:
//  - State is IDLE; bl, wl, s_ready, busy and done are all 0.
//  - The row counter and chunk counter are 0.
//  States and transitions:
//  - IDLE/DONE --start--> LOAD. row=0, chunk=0, done<=0, busy<=1.
//  - LOAD:
//    - s_ready=1.
//    - On an s_valid&&s_ready handshake, write bl[chunk*DIN_W +: DIN_W], truncated at BL_W-1.
//    - On the last chunk, the s_data bits above BL_W-1-chunk*DIN_W are ignored.
//    - After the handshake, chunk++.
//    - The handshake on chunk CHUNKS-1 moves the FSM to SETTLE.
//    - No handshake: the FSM waits indefinitely; there is no timeout.
//  - SETTLE: 1 cycle, s_ready=0. bl is stable and wl is all-zero, giving BL setup before WL.
//  - PULSE: wl[row]=1, all other wl bits 0, for exactly WL_PULSE cycles; bl held.
//  - HOLD: 1 cycle, wl=0, bl held (hold time).
//    - If row<WL_W-1: row++, chunk=0, go to LOAD.
//    - Otherwise go to DONE.
//  - DONE: done=1, busy=0, bl<=0, wl=0, s_ready=0.
//  Timing and structure:
//  - Per-row minimum latency is CHUNKS+1+WL_PULSE+1 cycles, with s_valid held high.
//  - bl is not cleared between rows; each row fully overwrites it.
//  - All outputs are registered (no combinational path from s_valid to s_ready).
//  Boundary cases:
//  - start while busy: ignored; there is no restart.
//  - start and abort in the same cycle: abort wins.
//  - abort in any state: next cycle is IDLE; bl, wl, busy, done and the counters all go to 0.
//    - Any partially written row is discarded; wl never completes its pulse.
//  - s_valid while not in LOAD: no handshake, data is not consumed.
//  - global_resetn asserted mid-pulse: wl drops to 0 asynchronously.
//  - Invariant: at most one wl bit is high in any cycle.
//  - Invariant: wl is never high in the same cycle as a bl change.
//  - Counters: row is clog2(WL_W) bits and chunk is clog2(CHUNKS) bits; neither ever wraps.
// TESTING  (bench params BL_W=10 WL_W=3 DIN_W=4 WL_PULSE=2; CHUNKS=3)
//  1 Reset: reset asserted -> bl=0, wl=0, s_ready=0, busy=0, done=0; start ignored while in reset.
//  2 Full load:
//    - Stimulus: start, s_valid=1, words 0x5,0xA,0xF (row0), 0x1,0x2,0x3 (row1), 0x0,0x0,0x3 (row2).
//    - bl during row0 pulse = 10'b11_1010_0101, with bit0=1 at bl[0].
//    - wl goes 100 (2 cycles), then 010, then 001.
//    - done=1 exactly 3*(3+1+2+1)=21 cycles after start.
//  3 Backpressure: s_valid low for 5 cycles between chunk0 and chunk1.
//    -> s_ready stays 1, wl stays 0, the result is unchanged, and done is 5 cycles later.
//  4 Partial last chunk: row word2 = 0xF -> only bl[8:9] set, bits 10..11 dropped.
//  5 Abort: abort during row1 PULSE cycle 1 -> next cycle wl=0, bl=0, busy=0, done=0.
//    - A subsequent start reloads from row0.
//  6 Start while busy: start mid-LOAD -> ignored.
//    - start in DONE -> done=0 next cycle, new load begins.
//  All cases: check the invariant "popcount(wl)<=1 and bl stable whenever |wl" every cycle.

Source files
------------

// File: rtl/ql_bl_wl_config_loader.sv
// Configuration-memory loader for the fabric's BL/WL array.
// Streams DIN_W-bit words into a BL_W-bit bit-line frame, then strobes one
// word-line row to write it, walking rows 0..WL_W-1 once per load.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; all outputs low
// LOAD    | accepting stream words into bl, one chunk per handshake
// SETTLE  | one cycle of bl setup before the word-line rises
// PULSE   | wl[row] held high for WL_PULSE cycles; bl frozen
// HOLD    | one cycle of bl hold after the word-line falls
// DONE    | every row written; done high until the next start/abort
module ql_bl_wl_config_loader #(
    parameter int BL_W     = 514,
    parameter int WL_W     = 407,
    parameter int DIN_W    = 32,
    parameter int WL_PULSE = 2
) (
    input  logic             clk,
    input  logic             global_resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [DIN_W-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [0:BL_W-1]  bl,
    output logic [0:WL_W-1]  wl,
    output logic             busy,
    output logic             done
);

    localparam int CHUNKS  = (BL_W + DIN_W - 1) / DIN_W;
    localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int ROW_W   = (WL_W > 1) ? $clog2(WL_W) : 1;
    localparam int PULSE_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_PULSE  = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t             state, state_next;
    logic [ROW_W-1:0]   row, row_next;
    logic [CHUNK_W-1:0] chunk, chunk_next;
    logic [PULSE_W-1:0] pulse_cnt, pulse_next;
    logic [0:BL_W-1]    bl_next;
    logic [0:WL_W-1]    wl_next;
    logic               s_ready_next;
    logic               busy_next;
    logic               done_next;
    logic               handshake;

    // s_ready is a registered copy of (state == LOAD), so it qualifies the
    // handshake without creating a path from s_valid to s_ready.
    assign handshake = s_valid && s_ready;

    // State, counters and every output are registered together so that all
    // outputs come straight from flops.
    always_ff @(posedge clk or negedge global_resetn) begin
        if (!global_resetn) begin
            state     <= ST_IDLE;
            row       <= '0;
            chunk     <= '0;
            pulse_cnt <= '0;
            bl        <= '0;
            wl        <= '0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            row       <= row_next;
            chunk     <= chunk_next;
            pulse_cnt <= pulse_next;
            bl        <= bl_next;
            wl        <= wl_next;
            s_ready   <= s_ready_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    // Next-state, counter and next-output decode.
    always_comb begin
        state_next = state;
        row_next   = row;
        chunk_next = chunk;
        pulse_next = pulse_cnt;
        bl_next    = bl;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    row_next   = '0;
                    chunk_next = '0;
                end
            end
            ST_LOAD: begin
                if (handshake) begin
                    // Bits past BL_W-1 in the last chunk have no home and are dropped.
                    for (int b = 0; b < BL_W; b++) begin
                        if (chunk == CHUNK_W'(b / DIN_W)) begin
                            bl_next[b] = s_data[b % DIN_W];
                        end
                    end
                    // The chunk counter parks on the last chunk rather than
                    // wrapping; HOLD clears it for the next row.
                    if (chunk == CHUNK_W'(CHUNKS - 1)) begin
                        state_next = ST_SETTLE;
                    end else begin
                        chunk_next = chunk + 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                state_next = ST_PULSE;
                pulse_next = PULSE_W'(WL_PULSE - 1);
            end
            ST_PULSE: begin
                if (pulse_cnt == '0) begin
                    state_next = ST_HOLD;
                end else begin
                    pulse_next = pulse_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                chunk_next = '0;
                if (row < ROW_W'(WL_W - 1)) begin
                    row_next   = row + 1'b1;
                    state_next = ST_LOAD;
                end else begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (state_next == ST_DONE) begin
            bl_next = '0;
        end

        // Abort overrides everything, including a same-cycle start.
        if (abort) begin
            state_next = ST_IDLE;
            row_next   = '0;
            chunk_next = '0;
            pulse_next = '0;
            bl_next    = '0;
        end

        s_ready_next = (state_next == ST_LOAD);
        busy_next    = (state_next == ST_LOAD) || (state_next == ST_SETTLE) ||
                       (state_next == ST_PULSE) || (state_next == ST_HOLD);
        done_next    = (state_next == ST_DONE);

        // Word-line decode; only reachable value is one-hot or all-zero.
        for (int i = 0; i < WL_W; i++) begin
            wl_next[i] = (state_next == ST_PULSE) && (row_next == ROW_W'(i));
        end
    end

endmodule

// File: tb/tb_ql_bl_wl_config_loader.sv
// Directed bench for ql_bl_wl_config_loader with a 10-bit frame, 3 rows,
// 4-bit stream words and a 2-cycle word-line pulse.
module tb_ql_bl_wl_config_loader;

    logic       clk;
    logic       global_resetn;
    logic       start;
    logic       abort;
    logic [3:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [0:9] bl;
    logic [0:2] wl;
    logic       busy;
    logic       done;

    logic [9:0] bl_num;
    logic [9:0] bl_prev;
    logic       mon_en;
    int         n_tests;
    int         n_fail;

    ql_bl_wl_config_loader #(
        .BL_W(10), .WL_W(3), .DIN_W(4), .WL_PULSE(2)
    ) dut (
        .clk(clk),
        .global_resetn(global_resetn),
        .start(start),
        .abort(abort),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .bl(bl),
        .wl(wl),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bl_num[i] == bl[i], so hex constants read with bit 0 = bl[0].
    always_comb begin
        for (int i = 0; i < 10; i++) bl_num[i] = bl[i];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every-cycle invariants: wl one-hot-or-zero, bl frozen while wl is high.
    always @(negedge clk) begin
        if (mon_en && global_resetn) begin
            n_tests++;
            assert ($countones(wl) <= 1) else begin
                n_fail++;
                $error("FAIL wl_onehot: observed %b expected at most one bit set", wl);
            end
            if (|wl) begin
                n_tests++;
                assert (bl_num === bl_prev) else begin
                    n_fail++;
                    $error("FAIL bl_stable: observed %0h expected %0h", bl_num, bl_prev);
                end
            end
        end
        bl_prev = bl_num;
    end

    // Runs one row starting in LOAD. gap inserts idle cycles after chunk 0,
    // start_mid raises start during chunk 1, abort_mid aborts in PULSE cycle 1.
    task automatic do_row(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2,
                          input int gap, input logic [9:0] exp_bl, input logic [2:0] exp_wl,
                          input bit last, input bit start_mid, input bit abort_mid);
        s_valid = 1'b1; s_data = w0; tick();
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0; s_data = 4'hC;
            check("gap_ready", 32'(s_ready), 1);
            check("gap_wl", 32'(wl), 0);
            tick();
        end
        s_valid = 1'b1; s_data = w1; start = start_mid; tick();
        start = 1'b0;
        s_data = w2; tick();
        check("settle_ready", 32'(s_ready), 0);
        check("settle_wl", 32'(wl), 0);
        check("settle_bl", 32'(bl_num), 32'(exp_bl));
        s_data = 4'hE;
        tick();
        check("pulse1_wl", 32'(wl), 32'(exp_wl));
        check("pulse1_bl", 32'(bl_num), 32'(exp_bl));
        check("pulse1_busy", 32'(busy), 1);
        if (abort_mid) begin
            abort = 1'b1; start = 1'b1; tick();
            abort = 1'b0; start = 1'b0;
            check("abort_wl", 32'(wl), 0);
            check("abort_bl", 32'(bl_num), 0);
            check("abort_busy", 32'(busy), 0);
            check("abort_done", 32'(done), 0);
            check("abort_ready", 32'(s_ready), 0);
            return;
        end
        tick();
        check("pulse2_wl", 32'(wl), 32'(exp_wl));
        tick();
        check("hold_wl", 32'(wl), 0);
        check("hold_bl", 32'(bl_num), 32'(exp_bl));
        check("hold_done", 32'(done), 0);
        tick();
        if (last) begin
            check("done_done", 32'(done), 1);
            check("done_busy", 32'(busy), 0);
            check("done_bl", 32'(bl_num), 0);
            check("done_wl", 32'(wl), 0);
            check("done_ready", 32'(s_ready), 0);
        end else begin
            check("next_ready", 32'(s_ready), 1);
            check("next_busy", 32'(busy), 1);
            check("next_wl", 32'(wl), 0);
        end
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_ready", 32'(s_ready), 1);
        check("start_done", 32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; mon_en = 1'b0;
        global_resetn = 1'b0; start = 1'b1; abort = 1'b0;
        s_valid = 1'b1; s_data = 4'h7;

        // Reset, with start and s_valid asserted throughout.
        tick(); tick(); tick();
        check("rst_bl", 32'(bl_num), 0);
        check("rst_wl", 32'(wl), 0);
        check("rst_ready", 32'(s_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        start = 1'b0; global_resetn = 1'b1; mon_en = 1'b1;
        tick(); tick();
        check("idle_busy", 32'(busy), 0);
        check("idle_ready", 32'(s_ready), 0);
        check("idle_bl", 32'(bl_num), 0);

        // Full load, s_valid held high: done lands 21 cycles after start.
        do_start();
        do_row(4'h5, 4'hA, 4'hF, 0, 10'h3A5, 3'b100, 1'b0, 1'b0, 1'b0);
        do_row(4'h1, 4'h2, 4'h3, 0, 10'h321, 3'b010, 1'b0, 1'b0, 1'b0);
        do_row(4'h0, 4'h0, 4'h3, 0, 10'h300, 3'b001, 1'b1, 1'b0, 1'b0);
        tick();
        check("done_level", 32'(done), 1);

        // Start from DONE; 5-cycle backpressure; start mid-LOAD ignored;
        // truncated last chunks (0xF keeps only bl[8:9]).
        do_start();
        do_row(4'h5, 4'hA, 4'hF, 5, 10'h3A5, 3'b100, 1'b0, 1'b0, 1'b0);
        do_row(4'h7, 4'h8, 4'hF, 0, 10'h387, 3'b010, 1'b0, 1'b1, 1'b0);
        do_row(4'h0, 4'h0, 4'hF, 0, 10'h300, 3'b001, 1'b1, 1'b0, 1'b0);

        // Abort (with a coincident start) during row 1 PULSE, then reload.
        do_start();
        do_row(4'h2, 4'h4, 4'h1, 0, 10'h142, 3'b100, 1'b0, 1'b0, 1'b0);
        do_row(4'h3, 4'h6, 4'h2, 0, 10'h263, 3'b010, 1'b0, 1'b0, 1'b1);
        tick();
        check("post_abort_busy", 32'(busy), 0);
        check("post_abort_bl", 32'(bl_num), 0);
        do_start();
        do_row(4'h9, 4'h0, 4'h2, 0, 10'h209, 3'b100, 1'b0, 1'b0, 1'b0);
        do_row(4'h1, 4'h1, 4'h1, 0, 10'h111, 3'b010, 1'b0, 1'b0, 1'b0);
        do_row(4'hF, 4'hF, 4'hF, 0, 10'h3FF, 3'b001, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a word-line pulse.
        do_start();
        s_data = 4'hA; tick();
        s_data = 4'h5; tick();
        s_data = 4'h0; tick();
        tick();
        check("arst_pre_wl", 32'(wl), 32'(3'b100));
        global_resetn = 1'b0;
        #1;
        check("arst_wl", 32'(wl), 0);
        check("arst_bl", 32'(bl_num), 0);
        check("arst_busy", 32'(busy), 0);
        tick();
        global_resetn = 1'b1;
        tick();
        check("arst_idle_ready", 32'(s_ready), 0);

        s_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
